// File: rtl/lcd_seq_pkg.sv
// Shared defaults, state encoding and window-entry type for the LCD write sequencer.
package lcd_seq_pkg;

   localparam int unsigned DEF_PERIOD    = 203;
   localparam int unsigned DEF_N_WIN     = 4;
   localparam int unsigned WIN_CNT_W     = 8;
   localparam int unsigned WIN_DATA_W    = 8;
   localparam logic [7:0]  LCD_IDLE_DATA = 8'h1C;

   typedef enum logic [0:0] {StIdle, StRun} seq_state_e;

   typedef struct packed {
      logic                  valid;
      logic [WIN_CNT_W-1:0]  lo;
      logic [WIN_CNT_W-1:0]  hi;
      logic [WIN_DATA_W-1:0] data;
   } win_entry_t;

   // One spare code point so an index equal to N_WIN can be presented and rejected.
   function automatic int unsigned addr_width(input int unsigned n_win);
      return $clog2(n_win + 1);
   endfunction

endpackage

// File: rtl/lcd_write_sequencer_if.sv
// Window-table configuration bus plus the LCD write/data outputs of the sequencer.
interface lcd_write_sequencer_if
   import lcd_seq_pkg::*;
#(
   parameter int unsigned DATA_W = WIN_DATA_W,
   parameter int unsigned CNT_W  = WIN_CNT_W,
   parameter int unsigned ADDR_W = addr_width(DEF_N_WIN)
);

   logic              cfg_we;
   logic [ADDR_W-1:0] cfg_addr;
   logic              cfg_valid;
   logic [CNT_W-1:0]  cfg_lo;
   logic [CNT_W-1:0]  cfg_hi;
   logic [DATA_W-1:0] cfg_data;
   logic              write;
   logic [DATA_W-1:0] lcd_data;

   modport master (
      output cfg_we, cfg_addr, cfg_valid, cfg_lo, cfg_hi, cfg_data,
      input  write, lcd_data
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_valid, cfg_lo, cfg_hi, cfg_data,
      output write, lcd_data
   );

endinterface

// File: rtl/lcd_win_table.sv
// Programmable window table: entry registers and lowest-index-wins hit encoder.
module lcd_win_table
   import lcd_seq_pkg::*;
#(
   parameter int unsigned N_WIN  = DEF_N_WIN,
   parameter int unsigned ADDR_W = addr_width(DEF_N_WIN)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cfg_we_i,
   input  logic [ADDR_W-1:0]     cfg_addr_i,
   input  logic                  cfg_valid_i,
   input  logic [WIN_CNT_W-1:0]  cfg_lo_i,
   input  logic [WIN_CNT_W-1:0]  cfg_hi_i,
   input  logic [WIN_DATA_W-1:0] cfg_data_i,
   input  logic [WIN_CNT_W-1:0]  count_i,
   output logic                  hit_o,
   output logic [WIN_DATA_W-1:0] hit_data_o
);

   win_entry_t entries_q [N_WIN];
   win_entry_t entries_d [N_WIN];

   // Out-of-range addresses match no index, so they write nothing.
   always_comb begin
      for (int unsigned i = 0; i < N_WIN; i++) begin
         entries_d[i] = entries_q[i];
         if (cfg_we_i && (cfg_addr_i == ADDR_W'(i))) begin
            entries_d[i] = '{valid: cfg_valid_i, lo: cfg_lo_i, hi: cfg_hi_i, data: cfg_data_i};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < N_WIN; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_WIN; i++) begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

   always_comb begin
      hit_o      = 1'b0;
      hit_data_o = '0;
      for (int i = int'(N_WIN) - 1; i >= 0; i--) begin
         if (entries_q[i].valid && (entries_q[i].lo <= count_i) && (count_i <= entries_q[i].hi)) begin
            hit_o      = 1'b1;
            hit_data_o = entries_q[i].data;
         end
      end
   end

endmodule

// File: rtl/lcd_write_sequencer.sv
// Frame counter and IDLE/RUN sequencer that emits table-selected LCD bytes one cycle after
// the count that selected them.
module lcd_write_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int unsigned       DATA_W    = WIN_DATA_W,
   parameter int unsigned       CNT_W     = WIN_CNT_W,
   parameter int unsigned       PERIOD    = DEF_PERIOD,
   parameter int unsigned       N_WIN     = DEF_N_WIN,
   parameter logic [DATA_W-1:0] IDLE_DATA = LCD_IDLE_DATA
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        one_shot,
   input  logic                        start,
   lcd_write_sequencer_if.slave        bus,
   output logic                        busy,
   output logic                        frame_done,
   output logic [CNT_W-1:0]            count
);

   localparam int unsigned ADDR_W = addr_width(N_WIN);

   seq_state_e        state_q, state_d;
   logic              mode_q, mode_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              hit;
   logic [DATA_W-1:0] hit_data;
   logic              wrap;

   lcd_win_table #(
      .N_WIN  (N_WIN),
      .ADDR_W (ADDR_W)
   ) u_win_table (
      .clk_i       (clk),
      .rst_ni      (rst),
      .cfg_we_i    (bus.cfg_we),
      .cfg_addr_i  (bus.cfg_addr),
      .cfg_valid_i (bus.cfg_valid),
      .cfg_lo_i    (bus.cfg_lo),
      .cfg_hi_i    (bus.cfg_hi),
      .cfg_data_i  (bus.cfg_data),
      .count_i     (count_q),
      .hit_o       (hit),
      .hit_data_o  (hit_data)
   );

   assign wrap = (state_q == StRun) && en && (count_q == CNT_W'(PERIOD - 1));

   // mode_q is the one_shot value latched at the start of the frame in progress.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      count_d = count_q;
      case (state_q)
         StIdle: begin
            if (en && (!one_shot || start)) begin
               state_d = StRun;
               mode_d  = one_shot;
            end
         end
         StRun: begin
            if (wrap) begin
               count_d = '0;
               if (mode_q) begin
                  state_d = StIdle;
               end else begin
                  mode_d = one_shot;
               end
            end else if (en) begin
               count_d = count_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d  = (state_d == StRun);
      done_d  = wrap;
      write_d = (state_q == StRun) && en && hit;
      data_d  = write_d ? hit_data : IDLE_DATA;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         mode_q  <= 1'b0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         write_q <= 1'b0;
         data_q  <= IDLE_DATA;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         write_q <= write_d;
         data_q  <= data_d;
      end
   end

   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign count        = count_q;
   assign bus.write    = write_q;
   assign bus.lcd_data = data_q;

endmodule
